// File: rtl/multadd_sched.sv
// multadd_sched: round-robin scheduler feeding one shared multiply-add unit.
// Each lane holds a credit count of operations it has not yet consumed. Grants
// are issued one per cycle. The addend is delayed to meet the unit's c input,
// and a valid/lane delay line tags each result as it leaves the unit.
module multadd_sched #(
    parameter int NUM_LANES = 4,
    parameter int MAX_OUT   = 8,
    parameter int MULT_LAT  = 18,
    parameter int ADD_LAT   = 6,
    localparam int LW       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_LANES-1:0]     req_valid,
    output logic [NUM_LANES-1:0]     req_ready,
    input  logic [64*NUM_LANES-1:0]  req_a,
    input  logic [64*NUM_LANES-1:0]  req_b,
    input  logic [128*NUM_LANES-1:0] req_c,
    input  logic [NUM_LANES-1:0]     credit_ret,
    output logic [63:0]              ma_a,
    output logic [63:0]              ma_b,
    output logic [127:0]             ma_c,
    input  logic [127:0]             ma_p,
    output logic                     rsp_valid,
    output logic [LW-1:0]            rsp_lane,
    output logic [127:0]             rsp_p,
    output logic                     busy,
    output logic                     credit_err
);
    localparam int CW    = $clog2(MAX_OUT + 1);
    localparam int DEPTH = 1 + MULT_LAT + ADD_LAT;  // grant -> result cycles
    localparam int CDEP  = 1 + MULT_LAT;            // grant -> ma_c cycles

    logic [LW-1:0]                 rr_q, rr_d;
    logic [NUM_LANES-1:0][CW-1:0]  cnt_q, cnt_d;
    logic                          err_q, err_d;
    logic [NUM_LANES-1:0]          elig, grant;
    logic                          gnt_any;
    logic [LW-1:0]                 gnt_lane;
    logic [63:0]                   gnt_a, gnt_b;
    logic [127:0]                  gnt_c;
    logic [63:0]                   ma_a_q, ma_b_q;
    logic [DEPTH:1]                vld_pipe_q;
    logic [DEPTH:1][LW-1:0]        lane_pipe_q;
    logic [CDEP:1][127:0]          c_pipe_q;

    // Round-robin pick of the first eligible lane at or after rr_q; no grants in reset.
    always_comb begin
        int idx;
        idx      = 0;
        elig     = '0;
        grant    = '0;
        gnt_any  = 1'b0;
        gnt_lane = '0;
        for (int i = 0; i < NUM_LANES; i++)
            elig[i] = req_valid[i] && (cnt_q[i] < CW'(MAX_OUT));
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = (int'(rr_q) + k) % NUM_LANES;
            if (!rst && !gnt_any && elig[idx]) begin
                gnt_any    = 1'b1;
                gnt_lane   = LW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    // Operand mux for the granted lane; zero when nothing is issued.
    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        gnt_c = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grant[i]) begin
                gnt_a = req_a[64*i +: 64];
                gnt_b = req_b[64*i +: 64];
                gnt_c = req_c[128*i +: 128];
            end
        end
    end

    // Credit counts and pointer update; a return against an empty count is flagged, not applied.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        rr_d  = rr_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (credit_ret[i] && cnt_q[i] == '0)
                err_d = 1'b1;
            cnt_d[i] = cnt_q[i] + CW'(grant[i]) - CW'(credit_ret[i] && cnt_q[i] != '0);
        end
        if (gnt_any)
            rr_d = (gnt_lane == LW'(NUM_LANES - 1)) ? '0 : gnt_lane + 1'b1;
    end

    // State registers and delay lines; reset drops every in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            ma_a_q      <= '0;
            ma_b_q      <= '0;
            vld_pipe_q  <= '0;
            lane_pipe_q <= '0;
            c_pipe_q    <= '0;
        end else begin
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            ma_a_q      <= gnt_a;
            ma_b_q      <= gnt_b;
            vld_pipe_q  <= {vld_pipe_q[DEPTH-1:1], gnt_any};
            lane_pipe_q <= {lane_pipe_q[DEPTH-1:1], gnt_lane};
            c_pipe_q    <= {c_pipe_q[CDEP-1:1], gnt_c};
        end
    end

    assign req_ready  = grant;
    assign ma_a       = ma_a_q;
    assign ma_b       = ma_b_q;
    assign ma_c       = c_pipe_q[CDEP];
    assign rsp_p      = ma_p;
    // Results and activity are masked while reset is held.
    assign rsp_valid  = vld_pipe_q[DEPTH] & ~rst;
    assign rsp_lane   = rst ? '0 : lane_pipe_q[DEPTH];
    assign busy       = (|vld_pipe_q) & ~rst;
    assign credit_err = err_q;
endmodule

// File: tb/tb_multadd_sched.sv
// Bench for multadd_sched: directed phases, a cycle-indexed grant history as
// the reference model, and a stand-in multiply-add unit driving ma_p.
module tb_multadd_sched;
    localparam int NL = 4;
    localparam int MO = 8;
    localparam int ML = 18;
    localparam int AL = 6;
    localparam int D  = 1 + ML + AL;
    localparam int HN = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NL-1:0]     req_valid = '0;
    logic [NL-1:0]     credit_ret = '0;
    logic [NL-1:0]     req_ready;
    logic [64*NL-1:0]  req_a, req_b;
    logic [128*NL-1:0] req_c;
    logic [63:0]       ma_a, ma_b;
    logic [127:0]      ma_c, ma_p = '0, rsp_p;
    logic              rsp_valid, busy, credit_err;
    logic [1:0]        rsp_lane;
    logic [63:0]       ra[NL], rb[NL];
    logic [127:0]      rc[NL];

    assign req_a = {ra[3], ra[2], ra[1], ra[0]};
    assign req_b = {rb[3], rb[2], rb[1], rb[0]};
    assign req_c = {rc[3], rc[2], rc[1], rc[0]};

    multadd_sched #(.NUM_LANES(NL), .MAX_OUT(MO), .MULT_LAT(ML), .ADD_LAT(AL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .credit_ret(credit_ret),
        .ma_a(ma_a), .ma_b(ma_b), .ma_c(ma_c), .ma_p(ma_p),
        .rsp_valid(rsp_valid), .rsp_lane(rsp_lane), .rsp_p(rsp_p),
        .busy(busy), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Stand-in multiply-add unit: signed a times unsigned b as a 128-bit product,
    // c added to each 64-bit half independently (no carry between halves).
    function automatic logic [127:0] mac(input logic [63:0] a, input logic [63:0] b,
                                         input logic [127:0] c);
        logic [127:0] pr;
        pr = {{64{a[63]}}, a} * {64'd0, b};
        return {pr[127:64] + c[127:64], pr[63:0] + c[63:0]};
    endfunction

    // Model: one record per cycle of what the scheduler must grant.
    int           m_cnt[NL];
    int           m_rr = 0;
    bit           m_err = 1'b0;
    int           last_rst = 0;
    bit           h_v[HN];
    int           h_l[HN];
    logic [63:0]  h_a[HN], h_b[HN];
    logic [127:0] h_c[HN];
    logic [63:0]  u_a[HN], u_b[HN];
    logic [127:0] u_c[HN];

    // A grant counts only if it happened after the most recent reset cycle.
    function automatic bit rec(input int g);
        if (g < 0 || g <= last_rst) return 1'b0;
        return h_v[g];
    endfunction

    // Unit output for the current cycle from what the DUT actually drove earlier.
    always @(posedge clk) begin
        #2;
        if (cyc >= ML + AL && cyc < HN)
            ma_p = mac(u_a[cyc-ML-AL], u_b[cyc-ML-AL], u_c[cyc-AL]);
        else
            ma_p = '0;
    end

    // Per-cycle compare against the model, then advance the model.
    logic [NL-1:0] er;
    int            gl, t, li;
    bit            ev, eb;
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < HN) begin
            t  = cyc;
            er = '0;
            gl = -1;
            if (!rst)
                for (int k = 0; k < NL; k++) begin
                    li = (m_rr + k) % NL;
                    if (gl < 0 && req_valid[li] && m_cnt[li] < MO) gl = li;
                end
            h_v[t] = (gl >= 0);
            h_l[t] = gl;
            if (gl >= 0) begin
                er[gl] = 1'b1;
                h_a[t] = ra[gl];
                h_b[t] = rb[gl];
                h_c[t] = rc[gl];
            end
            u_a[t] = ma_a;
            u_b[t] = ma_b;
            u_c[t] = ma_c;

            chk("req_ready", req_ready, er);
            chk("ma_a", ma_a, rec(t-1) ? h_a[t-1] : 64'd0);
            chk("ma_b", ma_b, rec(t-1) ? h_b[t-1] : 64'd0);
            chk("ma_c", ma_c, rec(t-1-ML) ? h_c[t-1-ML] : 128'd0);
            ev = !rst && rec(t-D);
            chk("rsp_valid", rsp_valid, ev);
            chk("rsp_lane", rsp_lane, ev ? h_l[t-D] : 0);
            if (ev) chk("rsp_p", rsp_p, mac(h_a[t-D], h_b[t-D], h_c[t-D]));
            eb = 1'b0;
            if (!rst)
                for (int g = t - D; g < t; g++)
                    if (rec(g)) eb = 1'b1;
            chk("busy", busy, eb);
            chk("credit_err", credit_err, m_err);

            if (rst) begin
                for (int i = 0; i < NL; i++) m_cnt[i] = 0;
                m_rr     = 0;
                m_err    = 1'b0;
                last_rst = t;
            end else begin
                for (int i = 0; i < NL; i++) begin
                    if (credit_ret[i] && m_cnt[i] == 0) m_err = 1'b1;
                    else if (credit_ret[i]) m_cnt[i]--;
                    if (gl == i) m_cnt[i]++;
                end
                if (gl >= 0) m_rr = (gl + 1) % NL;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lands on the negedge of cycle c (c must not be in the past).
    task automatic wait_to(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_ops(input int k);
        for (int i = 0; i < NL; i++) begin
            ra[i] = 64'(k * 16 + i + 1);
            rb[i] = 64'hFFFF_0000_0000_0000 + 64'(k);
            rc[i] = {64'(k + 100), ~64'(k)};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int g, n;
    initial begin
        for (int i = 0; i < NL; i++) begin
            m_cnt[i] = 0;
            ra[i] = '0; rb[i] = '0; rc[i] = '0;
        end
        // Reset held for cycles 0..2
        tick(); tick();
        wait_to(2);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        tick();
        rst = 1'b0;

        // Single op on lane 2
        req_valid = 4'b0100;
        ra[2] = 64'd3; rb[2] = 64'd5; rc[2] = {64'd7, 64'd11};
        g = cyc;
        tick();
        req_valid = '0;
        wait_to(g + 1);
        chk("single_ma_a", ma_a, 3);
        chk("single_ma_b", ma_b, 5);
        wait_to(g + 19);
        chk("single_ma_c", ma_c, {64'd7, 64'd11});
        wait_to(g + 25);
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_lane", rsp_lane, 2);
        chk("single_rsp_p", rsp_p, {64'd7, 64'd26});
        tick(); credit_ret = 4'b0100;
        tick(); credit_ret = '0;

        // Wrap on lane 0
        req_valid = 4'b0001;
        ra[0] = 64'hFFFF_FFFF_FFFF_FFFF; rb[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        rc[0] = {64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
        g = cyc;
        tick();
        req_valid = '0;
        wait_to(g + 25);
        chk("wrap_rsp_p", rsp_p, {64'hFFFF_FFFF_FFFF_FFFE, 64'd3});
        tick(); credit_ret = 4'b0001;
        tick(); credit_ret = '0;

        // Reset in the middle of a stream of grants
        g = cyc;
        for (int k = 0; k < 10; k++) begin
            req_valid = 4'hF;
            set_ops(k);
            rst = (k == 5);
            @(negedge clk);
            if (k == 5) chk("midrst_ready", req_ready, 0);
            if (k == 6) chk("post_rst_first_lane", req_ready, 4'b0001);
            if (k == 9) chk("post_rst_fourth_lane", req_ready, 4'b1000);
            @(posedge clk); #1;
        end
        req_valid = '0;
        rst = 1'b0;
        wait_to(g + 27);
        chk("discarded_rsp", rsp_valid, 0);
        wait_to(g + 31);
        chk("post_rst_rsp_valid", rsp_valid, 1);
        chk("post_rst_rsp_lane", rsp_lane, 0);
        wait_to(g + 36);
        chk("post_rst_busy", busy, 0);
        tick(); credit_ret = 4'hF;
        tick(); credit_ret = '0;

        // Fairness with all lanes requesting
        g = cyc;
        for (int k = 0; k < 8; k++) begin
            req_valid = 4'hF;
            set_ops(k + 20);
            tick();
        end
        req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            wait_to(g + 25 + k);
            chk("fair_rsp_valid", rsp_valid, 1);
            chk("fair_rsp_lane", rsp_lane, k % 4);
        end
        tick(); credit_ret = 4'hF;
        tick(); credit_ret = 4'hF;
        tick(); credit_ret = '0;

        // Credit limit on lane 1
        req_valid = 4'b0010;
        set_ops(40);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[1]) n++;
            @(posedge clk); #1;
        end
        chk("credit_limit_grants", n, 8);
        credit_ret = 4'b0010;
        @(negedge clk);
        chk("no_credit_bypass", req_ready[1], 0);
        @(posedge clk); #1;
        credit_ret = '0;
        @(negedge clk);
        chk("grant_after_credit", req_ready[1], 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("limit_again", req_ready[1], 0);
        @(posedge clk); #1;
        req_valid = '0;

        // Simultaneous grant and return on lane 0 at count 5
        req_valid = 4'b0001;
        set_ops(50);
        repeat (5) tick();
        credit_ret = 4'b0001;
        @(negedge clk);
        chk("simul_grant", req_ready[0], 1);
        @(posedge clk); #1;
        credit_ret = '0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (req_ready[0]) n++;
            @(posedge clk); #1;
        end
        chk("simul_remaining_grants", n, 3);
        req_valid = '0;

        // Spurious return on empty lane 3
        credit_ret = 4'b1000;
        @(negedge clk);
        chk("err_before", credit_err, 0);
        @(posedge clk); #1;
        credit_ret = '0;
        req_valid = 4'b1000;
        @(negedge clk);
        chk("err_set", credit_err, 1);
        chk("empty_count_kept", req_ready, 4'b1000);
        @(posedge clk); #1;
        req_valid = '0;

        g = cyc;
        wait_to(g + 30);
        chk("final_busy", busy, 0);
        chk("err_sticky", credit_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
